// File: rtl/line_command_parser.sv
`default_nettype none
// ============================================================================
// Module   : line_command_parser
// Purpose  : Scans one completed 32-character PS/2 text line per command,
//            one character per clock, and decodes V<n> / A<n> / F commands
//            into the held velocity and angle registers and the fire strobe.
//            Malformed or out-of-range lines are rejected with cmd_error and
//            leave the held values untouched.
// Revision : 1.0 - initial release
// ============================================================================
module line_command_parser #(
  parameter int VEL_RESET   = 50,
  parameter int ANGLE_RESET = 45,
  parameter int VEL_MAX     = 255,
  parameter int ANGLE_MAX   = 180
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [255:0] ps2_line_content,
  input  logic         ps2_line_ready,
  output logic [31:0]  velocity,
  output logic [31:0]  angle,
  output logic         fire,
  output logic         cmd_valid,
  output logic         cmd_error,
  output logic         busy
);

  // Scanner states
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CMD      = 3'd1;
  localparam logic [2:0] SEP      = 3'd2;
  localparam logic [2:0] DIGIT    = 3'd3;
  localparam logic [2:0] TAIL     = 3'd4;
  localparam logic [2:0] DONE_OK  = 3'd5;
  localparam logic [2:0] DONE_ERR = 3'd6;

  // Command targets
  localparam logic [1:0] TGT_VEL  = 2'd0;
  localparam logic [1:0] TGT_ANG  = 2'd1;
  localparam logic [1:0] TGT_FIRE = 2'd2;

  localparam logic [9:0] VEL_MAX_W     = 10'(VEL_MAX);
  localparam logic [9:0] ANGLE_MAX_W   = 10'(ANGLE_MAX);
  localparam logic [9:0] VEL_RESET_W   = 10'(VEL_RESET);
  localparam logic [9:0] ANGLE_RESET_W = 10'(ANGLE_RESET);

  logic [2:0]   state;
  logic [255:0] line;
  logic [5:0]   idx;      // 0..32; 32 means "ran off the end of the line"
  logic [9:0]   acc;      // up to three decimal digits (max 999)
  logic [1:0]   ndig;     // digits accumulated so far
  logic [1:0]   target;
  logic [9:0]   vel_q;
  logic [9:0]   ang_q;

  logic [7:0]   ch;
  logic         is_term;
  logic         is_space;
  logic         is_digit;
  logic [3:0]   dval;
  logic [9:0]   acc_next;
  logic         range_ok;

  // Current character and its classification; index 32 reads as NUL so it
  // terminates the line like an explicit terminator would.
  always_comb begin
    ch       = idx[5] ? 8'h00 : line[{idx[4:0], 3'b000} +: 8];
    is_term  = (ch == 8'h00) || (ch == 8'h0D);
    is_space = (ch == 8'h20);
    is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    dval     = ch[3:0];
    // acc*10 + digit, never exceeds 999 because a fourth digit is rejected
    acc_next = (acc << 3) + (acc << 1) + {6'd0, dval};
    case (target)
      TGT_VEL: range_ok = (acc <= VEL_MAX_W);
      TGT_ANG: range_ok = (acc <= ANGLE_MAX_W);
      default: range_ok = 1'b1;
    endcase
  end

  // Line capture, character scan, and held-register update
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      line   <= '0;
      idx    <= '0;
      acc    <= '0;
      ndig   <= '0;
      target <= TGT_VEL;
      vel_q  <= VEL_RESET_W;
      ang_q  <= ANGLE_RESET_W;
    end else begin
      case (state)
        IDLE: begin
          if (ps2_line_ready) begin
            line  <= ps2_line_content;
            idx   <= '0;
            acc   <= '0;
            ndig  <= '0;
            state <= CMD;
          end
        end

        CMD: begin
          idx <= idx + 6'd1;
          if (is_space) begin
            state <= CMD;
          end else if (ch == 8'h56 || ch == 8'h76) begin
            target <= TGT_VEL;
            state  <= SEP;
          end else if (ch == 8'h41 || ch == 8'h61) begin
            target <= TGT_ANG;
            state  <= SEP;
          end else if (ch == 8'h46 || ch == 8'h66) begin
            target <= TGT_FIRE;
            state  <= TAIL;
          end else begin
            state <= DONE_ERR;
          end
        end

        SEP: begin
          idx <= idx + 6'd1;
          if (is_term) begin
            state <= DONE_ERR;
          end else if (is_space) begin
            state <= SEP;
          end else if (is_digit) begin
            acc   <= {6'd0, dval};
            ndig  <= 2'd1;
            state <= DIGIT;
          end else begin
            state <= DONE_ERR;
          end
        end

        DIGIT: begin
          idx <= idx + 6'd1;
          if (is_term) begin
            if (range_ok) begin
              state <= DONE_OK;
              if (target == TGT_VEL) vel_q <= acc;
              if (target == TGT_ANG) ang_q <= acc;
            end else begin
              state <= DONE_ERR;
            end
          end else if (is_digit) begin
            if (ndig == 2'd3) begin
              state <= DONE_ERR;
            end else begin
              acc  <= acc_next;
              ndig <= ndig + 2'd1;
            end
          end else if (is_space) begin
            state <= TAIL;
          end else begin
            state <= DONE_ERR;
          end
        end

        TAIL: begin
          idx <= idx + 6'd1;
          if (is_term) begin
            if (range_ok) begin
              state <= DONE_OK;
              if (target == TGT_VEL) vel_q <= acc;
              if (target == TGT_ANG) ang_q <= acc;
            end else begin
              state <= DONE_ERR;
            end
          end else if (!is_space) begin
            state <= DONE_ERR;
          end
        end

        DONE_OK:  state <= IDLE;
        DONE_ERR: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Result pulses and status decoded from the scanner state
  always_comb begin
    velocity  = {22'd0, vel_q};
    angle     = {22'd0, ang_q};
    cmd_valid = (state == DONE_OK);
    cmd_error = (state == DONE_ERR);
    fire      = (state == DONE_OK) && (target == TGT_FIRE);
    busy      = (state == CMD) || (state == SEP) || (state == DIGIT) || (state == TAIL);
  end

endmodule
`default_nettype wire

// File: tb/tb_line_command_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_command_parser
// Purpose  : Self-checking bench for line_command_parser: directed lines plus
//            randomized lines compared against a line-level reference parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_command_parser;

  logic         clock;
  logic         resetn;
  logic [255:0] ps2_line_content;
  logic         ps2_line_ready;
  logic [31:0]  velocity;
  logic [31:0]  angle;
  logic         fire;
  logic         cmd_valid;
  logic         cmd_error;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_vel  = 50;
  int exp_ang  = 45;

  line_command_parser dut (
    .clock            (clock),
    .resetn           (resetn),
    .ps2_line_content (ps2_line_content),
    .ps2_line_ready   (ps2_line_ready),
    .velocity         (velocity),
    .angle            (angle),
    .fire             (fire),
    .cmd_valid        (cmd_valid),
    .cmd_error        (cmd_error),
    .busy             (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Character at position i; positions past the end read as NUL
  function automatic logic [7:0] chr(input logic [255:0] l, input int i);
    if (i >= 32) return 8'h00;
    return l[i*8 +: 8];
  endfunction

  function automatic bit term(input logic [255:0] l, input int i);
    return (i >= 32) || (chr(l, i) == 8'h00) || (chr(l, i) == 8'h0D);
  endfunction

  function automatic bit dig(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  // Reference parser: walks the grammar of a whole line and reports whether
  // it is accepted, the index that decided the outcome, target and value.
  function automatic void model(input logic [255:0] l, output int ok, output int pos,
                                output int tgt, output int val);
    int i;
    int n;
    logic [7:0] c;
    ok = 0; tgt = 0; val = 0; i = 0;
    while (!term(l, i) && chr(l, i) == " ") i++;
    pos = i;
    if (term(l, i)) return;
    c = chr(l, i);
    if (c == "V" || c == "v") tgt = 0;
    else if (c == "A" || c == "a") tgt = 1;
    else if (c == "F" || c == "f") tgt = 2;
    else return;
    i++;
    if (tgt != 2) begin
      while (!term(l, i) && chr(l, i) == " ") i++;
      pos = i;
      if (term(l, i) || !dig(chr(l, i))) return;
      n = 0;
      while (!term(l, i) && dig(chr(l, i))) begin
        if (n == 3) begin pos = i; return; end
        val = val * 10 + int'(chr(l, i) - 8'h30);
        n++;
        i++;
      end
    end
    while (!term(l, i) && chr(l, i) == " ") i++;
    pos = i;
    if (!term(l, i)) return;
    if (tgt == 0 && val > 255) return;
    if (tgt == 1 && val > 180) return;
    ok = 1;
  endfunction

  function automatic logic [255:0] mk(input string s, input logic [7:0] pad);
    logic [255:0] l;
    for (int i = 0; i < 32; i++) l[i*8 +: 8] = (i < s.len()) ? s[i] : pad;
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    logic [7:0]   q[$];
    logic [7:0]   tc;
    int           tsel;
    repeat ($urandom_range(0, 2)) q.push_back(8'h20);
    case ($urandom_range(0, 8))
      0: q.push_back(8'h56);
      1: q.push_back(8'h76);
      2: q.push_back(8'h41);
      3: q.push_back(8'h61);
      4: q.push_back(8'h46);
      5: q.push_back(8'h66);
      6: q.push_back(8'h58);
      7: q.push_back(8'h37);
      default: ;
    endcase
    repeat ($urandom_range(0, 1)) q.push_back(8'h20);
    repeat ($urandom_range(0, 4)) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
    repeat ($urandom_range(0, 2)) q.push_back(8'h20);
    if ($urandom_range(0, 7) == 0) q.push_back(8'h21 + 8'($urandom_range(0, 90)));
    tsel = $urandom_range(0, 3);
    tc   = (tsel == 1) ? 8'h0D : 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (i < q.size())       l[i*8 +: 8] = q[i];
      else if (tsel == 2)     l[i*8 +: 8] = 8'h20;
      else if (i == q.size()) l[i*8 +: 8] = tc;
      else                    l[i*8 +: 8] = 8'($urandom);
    end
    return l;
  endfunction

  // Drive one line and check every cycle until the result and one beyond.
  // extra > 0 re-pulses ready during busy cycle T+extra with another line.
  task automatic run_line(input string tag, input logic [255:0] l, input int extra);
    int ok, pos, tgt, val, off;
    model(l, ok, pos, tgt, val);
    off = pos + 2;
    ps2_line_content = l;
    ps2_line_ready   = 1'b1;
    @(posedge clock); #1;
    ps2_line_ready = 1'b0;
    for (int c = 1; c < off; c++) begin
      if (c == extra) begin
        ps2_line_content = mk("A10", 8'h00);
        ps2_line_ready   = 1'b1;
      end else begin
        ps2_line_ready = 1'b0;
      end
      check({tag, " busy/pulses"}, {28'd0, busy, fire, cmd_valid, cmd_error}, 32'b1000);
      @(posedge clock); #1;
    end
    ps2_line_ready = 1'b0;
    if (ok != 0) begin
      if (tgt == 0) exp_vel = val;
      if (tgt == 1) exp_ang = val;
    end
    check({tag, " cmd_valid"}, {31'd0, cmd_valid}, 32'(ok));
    check({tag, " cmd_error"}, {31'd0, cmd_error}, 32'(ok == 0));
    check({tag, " fire"}, {31'd0, fire}, 32'(ok != 0 && tgt == 2));
    check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    check({tag, " velocity"}, velocity, 32'(exp_vel));
    check({tag, " angle"}, angle, 32'(exp_ang));
    @(posedge clock); #1;
    check({tag, " idle after"}, {28'd0, busy, fire, cmd_valid, cmd_error}, 32'd0);
  endtask

  initial begin
    resetn           = 1'b0;
    ps2_line_ready   = 1'b0;
    ps2_line_content = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset velocity", velocity, 32'd50);
    check("reset angle", angle, 32'd45);
    check("reset outputs", {28'd0, busy, fire, cmd_valid, cmd_error}, 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("post-reset velocity", velocity, 32'd50);
    check("post-reset outputs", {28'd0, busy, fire, cmd_valid, cmd_error}, 32'd0);

    // Directed lines
    run_line("V120", mk("V120", 8'h00), 0);
    run_line("a 180", mk("a 180", 8'h00), 0);
    run_line("A181", mk("A181", 8'h00), 0);
    run_line("F", mk("F", 8'h00), 0);
    run_line("sp f", mk(" f  ", 8'h0D), 0);
    run_line("V1234", mk("V1234", 8'h00), 0);
    run_line("X5", mk("X5", 8'h00), 0);
    run_line("V alone", mk("V", 8'h00), 0);
    run_line("V300", mk("V300", 8'h00), 0);
    run_line("V007", mk("V007", 8'h00), 0);
    run_line("V255 tail", mk("V255  ", 8'h0D), 0);
    run_line("empty", mk("", 8'h00), 0);
    run_line("V99 re-ready", mk("V99", 8'h00), 2);
    repeat (8) begin
      check("no second pulse", {28'd0, busy, fire, cmd_valid, cmd_error}, 32'd0);
      @(posedge clock); #1;
    end
    run_line("V+31 spaces", mk("V", 8'h20), 0);

    // Reset in the middle of a scan
    ps2_line_content = mk("V200", 8'h00);
    ps2_line_ready   = 1'b1;
    @(posedge clock); #1;
    ps2_line_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    exp_vel = 50;
    exp_ang = 45;
    check("midscan reset velocity", velocity, 32'd50);
    check("midscan reset outputs", {28'd0, busy, fire, cmd_valid, cmd_error}, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (6) begin
      @(posedge clock); #1;
      check("after abort", {28'd0, busy, fire, cmd_valid, cmd_error}, 32'd0);
      check("after abort velocity", velocity, 32'd50);
    end

    // Randomized lines
    for (int k = 0; k < 300; k++) run_line("rand", rand_line(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_command_parser.md
Name: line_command_parser

Overview:
- Sits directly downstream of ps2_processor_module.
- Consumes each completed 32-character PS/2 text line (ps2_line_content / ps2_line_ready) and scans it one character per clock.
- Decodes operator commands into the launcher registers VELOCITY and ANGLE, plus the one-cycle FIRE strobe, which feed display_controller and the processor.
- Malformed lines are rejected without disturbing the held values.

Parameters:
- VEL_RESET, 50, velocity value loaded at reset.
- ANGLE_RESET, 45, angle value loaded at reset.
- VEL_MAX, 255, largest accepted velocity.
- ANGLE_MAX, 180, largest accepted angle.

Ports:
- clock  in  1  system clock; every register is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ps2_line_content  in  256  line text; character i occupies bits [8i+7:8i], character 0 is the first typed.
- ps2_line_ready  in  1  line complete; treated as a level and qualified by the state.
- velocity  out  32  current velocity, zero-extended.
- angle  out  32  current angle, zero-extended.
- fire  out  1  one-cycle launch strobe.
- cmd_valid  out  1  one-cycle pulse: line accepted.
- cmd_error  out  1  one-cycle pulse: line rejected.
- busy  out  1  high while a line is being scanned.

Behaviour:
- Reset (asynchronous, resetn=0):
  - velocity=VEL_RESET, angle=ANGLE_RESET.
  - fire, cmd_valid, cmd_error, busy = 0.
  - State = IDLE; the latched line and the accumulator are cleared.
  - Reset asserted mid-scan aborts the scan with no pulse.
- Capture:
  - In IDLE, a cycle with ps2_line_ready=1 copies ps2_line_content into an internal 256-bit line register, clears index and accumulator, and moves to CMD.
  - busy=1 from the next cycle until the result cycle.
  - ps2_line_ready while busy is ignored; the line is dropped and no pulse is produced.
  - If ready is still high in the cycle after the result cycle, a new capture occurs; upstream holds ready for one cycle only.
- Terminator: 0x00, 0x0D, or index reaching 32.
- Scan: one character per cycle; index increments each cycle.
- States:
  - IDLE: as above.
  - CMD:
    - Leading 0x20 (space) is skipped.
    - 'V'/'v' -> SEP with target VEL.
    - 'A'/'a' -> SEP with target ANG.
    - 'F'/'f' -> TAIL with target FIRE.
    - Terminator on an empty line -> DONE_ERR.
    - Anything else -> DONE_ERR.
  - SEP:
    - Spaces are skipped.
    - Digit '0'-'9' -> DIGIT, with acc = digit.
    - Anything else, including a terminator -> DONE_ERR.
  - DIGIT:
    - Digit: acc = acc*10 + digit, using a 10-bit accumulator.
    - A fourth digit -> DONE_ERR.
    - Space -> TAIL.
    - Terminator -> range check.
    - Other character -> DONE_ERR.
  - TAIL:
    - Spaces are skipped.
    - Terminator -> range check (FIRE needs no check).
    - Any other character -> DONE_ERR.
  - Range check:
    - VEL: acc > VEL_MAX -> DONE_ERR, else DONE_OK.
    - ANG: acc > ANGLE_MAX -> DONE_ERR, else DONE_OK.
  - DONE_OK (one cycle):
    - cmd_valid=1.
    - VEL loads velocity=acc; ANG loads angle=acc; FIRE sets fire=1.
    - New register values are visible in this same cycle.
    - Returns to IDLE.
  - DONE_ERR (one cycle): cmd_error=1, registers unchanged, returns to IDLE.
- Latency: with the capture cycle at T and the terminator at index N (0..32), the DONE cycle is T+N+2. An early DONE_ERR occurs at T+k+2, where k is the offending index.
- Leading zeros are legal: "V007" gives 7.
- Characters after the terminator are never examined.
- fire, cmd_valid and cmd_error are mutually exclusive; each lasts exactly one cycle.
- busy=0 in the DONE cycle.
- velocity and angle are stable except in a DONE_OK cycle.

Test Plan:
1. Reset, then release → velocity=50, angle=45, fire=0, busy=0.
2. Line "V120" then 0x00 padding, ready pulse at T → cmd_valid at T+6, velocity=120, angle=45; busy high T+1..T+5.
3. Line "a 180", then "A181" → first: angle=180 with cmd_valid; second: cmd_error, angle stays 180.
4. Line "F" → fire high exactly one cycle at T+3, velocity and angle unchanged; " f  " followed by 0x0D also fires.
5. Malformed lines:
   - "V1234" → cmd_error at T+6, velocity unchanged.
   - "X5" → cmd_error at T+2.
   - "V" alone → cmd_error at T+3.
   - "V300" → cmd_error.
6. Ready pulsed again at T+2 during a "V99" scan → second line ignored, only one cmd_valid. resetn low at T+3 of a scan → velocity=50, no pulse; a 32-character line "V" followed by 31 spaces → cmd_error at T+34.
